// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner of the shared 32-bit datapath bus.
//
// Drives the one-hot output-enable vector for the per-source tri-state drivers
// and inserts TURNAROUND all-high-Z cycles between consecutive owners.
//
// Optional feature (macro BUS_ARB_TIMEOUT_EN): hold timeout that forcibly
// reclaims the bus after MAX_HOLD consecutive grant cycles. Without the macro
// no counter is built and timeout_flag is tied low.
//
// Ports:
//   clock        system clock, rising edge
//   reset        synchronous, active-high reset
//   req          per-source level request, held until served
//   rel          per-source end-of-transfer strobe; only the owner's bit counts
//                (named rel because "release" is a reserved word)
//   grant        registered one-hot output-enable, bit i -> driver i oe
//   grant_id     index of current owner, valid while grant != 0
//   bus_busy     high whenever the FSM is not idle
//   timeout_flag one-cycle pulse coincident with a forced release
module bus_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ID_W       = 2,
    parameter int unsigned TURNAROUND = 1,
    parameter int unsigned MAX_HOLD   = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] rel,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               bus_busy,
    output logic               timeout_flag
);

    localparam int unsigned TURN_W = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;

    // Elaboration-time parameter sanity checks.
    generate
        if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
            $error("bus_arbiter: NUM_REQ out of range");
        end
        if (NUM_REQ > (1 << ID_W)) begin : g_bad_id_w
            $error("bus_arbiter: ID_W too narrow for NUM_REQ");
        end
        if (TURNAROUND < 1) begin : g_bad_turn
            $error("bus_arbiter: TURNAROUND must be >= 1");
        end
        if (MAX_HOLD < 1) begin : g_bad_hold
            $error("bus_arbiter: MAX_HOLD must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [TURN_W-1:0]   turn_q, turn_d;
    logic                flag_d;
    logic                hold_expired;

    // Round-robin search: first set req bit at index >= ptr, wrapping.
    logic            found;
    logic [ID_W-1:0] winner;
    logic [ID_W:0]   idx;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = {1'b0, ptr_q} + (ID_W + 1)'(i);
            if (idx >= (ID_W + 1)'(NUM_REQ)) begin
                idx = idx - (ID_W + 1)'(NUM_REQ);
            end
            if (!found && req[idx[ID_W-1:0]]) begin
                found  = 1'b1;
                winner = idx[ID_W-1:0];
            end
        end
    end

    logic            owner_end;
    logic [ID_W-1:0] next_ptr;

    assign owner_end = rel[id_q] | ~req[id_q];
    assign next_ptr  = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int unsigned HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              flag_q;

    // hold_q counts completed grant cycles; it equals MAX_HOLD-1 in the
    // MAX_HOLD-th grant cycle, so the bus drops after exactly MAX_HOLD cycles.
    assign hold_expired = (state_q == ST_GRANT) && (hold_q == HOLD_W'(MAX_HOLD - 1));
    assign timeout_flag = flag_q;

    always_comb begin
        hold_d = hold_q;
        if (state_d == ST_GRANT && state_q != ST_GRANT) begin
            hold_d = '0;
        end else if (state_q == ST_GRANT && state_d == ST_GRANT) begin
            hold_d = hold_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hold_q <= '0;
            flag_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            flag_q <= flag_d;
        end
    end
`else
    assign hold_expired = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        turn_d  = turn_q;
        flag_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d = ST_GRANT;
                    grant_d = {{(NUM_REQ - 1){1'b0}}, 1'b1} << winner;
                    id_d    = winner;
                end
            end
            ST_GRANT: begin
                if (owner_end || hold_expired) begin
                    state_d = ST_TURN;
                    grant_d = '0;
                    ptr_d   = next_ptr;
                    turn_d  = '0;
                    // A normal end of tenure masks the timeout pulse.
                    flag_d  = hold_expired & ~owner_end;
                end
            end
            ST_TURN: begin
                if (turn_q == TURN_W'(TURNAROUND - 1)) begin
                    if (found) begin
                        state_d = ST_GRANT;
                        grant_d = {{(NUM_REQ - 1){1'b0}}, 1'b1} << winner;
                        id_d    = winner;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    turn_d = turn_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
            turn_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            turn_q  <= turn_d;
        end
    end

    assign grant    = grant_q;
    assign grant_id = id_q;
    assign bus_busy = (state_q != ST_IDLE);

endmodule
